ioctl_tx: RTL and testbench

- HPS-side transmitter for the ioctl download protocol.
- Takes a byte stream from a valid/ready source and replays it as an ioctl download session: ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout.
- Used as the built-in ROM/DIP/hiscore loader in simulation and standalone builds.
- Drives the same inputs that the core's download consumers receive (ROM loader at index 0, mod select at index 1, DIP bytes at index 254).

---
 rtl/ioctl_tx.sv | 216 +++++++++++++++++++++
 tb/tb_ioctl_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_tx.sv
// ioctl_tx: replays a valid/ready byte stream as an ioctl download session.
// Build macro IOCTL_TX_CHECKSUM_EN adds a mod-256 running checksum of the written bytes.
module ioctl_tx #(
    parameter int ADDR_W = 25,
    parameter int WR_GAP = 3,
    parameter int TAIL   = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        start_index,
    input  logic [ADDR_W-1:0] start_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    input  logic [7:0]        src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        checksum
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_SRC = 3'd2,
        ST_WRITE    = 3'd3,
        ST_GAP      = 3'd4,
        ST_TAIL     = 3'd5
    } state_t;

    localparam logic [3:0] GAP_LOAD  = 4'(WR_GAP - 1);
    localparam logic [3:0] TAIL_LOAD = 4'(TAIL);
    localparam bit         HAS_GAP   = (WR_GAP > 1);

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] len_r, len_next_s;
    logic [ADDR_W-1:0] count_r, count_next_s;
    logic [ADDR_W-1:0] addr_r, addr_next_s;
    logic [3:0]        timer_r, timer_next_s;
    logic              abort_flag_r, abort_flag_next_s;
    logic [7:0]        index_r, index_next_s;
    logic [7:0]        dout_r, dout_next_s;
    logic              wr_r, wr_next_s;
    logic              done_r, done_next_s;
    logic              aborted_r, aborted_next_s;
    logic              busy_r;
    logic              src_ready_r;
    logic              accept_s;

    // The only combinational output path: a simultaneous abort must refuse the byte.
    assign src_ready = src_ready_r & ~abort;
    assign accept_s  = src_valid & src_ready;

    // Next-state and next-output decode.
    always_comb begin
        state_next_s      = state_r;
        len_next_s        = len_r;
        count_next_s      = count_r;
        addr_next_s       = addr_r;
        timer_next_s      = timer_r;
        abort_flag_next_s = abort_flag_r;
        index_next_s      = index_r;
        dout_next_s       = dout_r;
        wr_next_s         = 1'b0;
        done_next_s       = 1'b0;
        aborted_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (start_len != '0)) begin
                    index_next_s      = start_index;
                    len_next_s        = start_len;
                    count_next_s      = '0;
                    abort_flag_next_s = 1'b0;
                    state_next_s      = ST_SETUP;
                end else if (start) begin
                    done_next_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    abort_flag_next_s = 1'b1;
                    timer_next_s      = TAIL_LOAD;
                    state_next_s      = ST_TAIL;
                end else begin
                    state_next_s = ST_WAIT_SRC;
                end
            end
            ST_WAIT_SRC: begin
                if (abort) begin
                    abort_flag_next_s = 1'b1;
                    timer_next_s      = TAIL_LOAD;
                    state_next_s      = ST_TAIL;
                end else if (accept_s) begin
                    dout_next_s  = src_data;
                    addr_next_s  = count_r;
                    wr_next_s    = 1'b1;
                    count_next_s = count_r + ADDR_W'(1);
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_WAIT_SRC;
                end
            end
            ST_WRITE: begin
                // count_r already includes the byte being written
                if (abort || (count_r == len_r)) begin
                    abort_flag_next_s = abort_flag_r | abort;
                    timer_next_s      = TAIL_LOAD;
                    state_next_s      = ST_TAIL;
                end else if (HAS_GAP) begin
                    timer_next_s = GAP_LOAD;
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_WAIT_SRC;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    abort_flag_next_s = 1'b1;
                    timer_next_s      = TAIL_LOAD;
                    state_next_s      = ST_TAIL;
                end else if (timer_r == 4'd1) begin
                    state_next_s = ST_WAIT_SRC;
                end else begin
                    timer_next_s = timer_r - 4'd1;
                end
            end
            ST_TAIL: begin
                if (timer_r == 4'd1) begin
                    done_next_s    = 1'b1;
                    aborted_next_s = abort_flag_r;
                    state_next_s   = ST_IDLE;
                end else begin
                    timer_next_s = timer_r - 4'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            len_r        <= '0;
            count_r      <= '0;
            addr_r       <= '0;
            timer_r      <= 4'd0;
            abort_flag_r <= 1'b0;
            index_r      <= 8'h00;
            dout_r       <= 8'h00;
            wr_r         <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            busy_r       <= 1'b0;
            src_ready_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            len_r        <= len_next_s;
            count_r      <= count_next_s;
            addr_r       <= addr_next_s;
            timer_r      <= timer_next_s;
            abort_flag_r <= abort_flag_next_s;
            index_r      <= index_next_s;
            dout_r       <= dout_next_s;
            wr_r         <= wr_next_s;
            done_r       <= done_next_s;
            aborted_r    <= aborted_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            src_ready_r  <= (state_next_s == ST_WAIT_SRC);
        end
    end

    assign busy           = busy_r;
    assign ioctl_download = busy_r;
    assign done           = done_r;
    assign aborted        = aborted_r;
    assign ioctl_index    = index_r;
    assign ioctl_wr       = wr_r;
    assign ioctl_addr     = addr_r;
    assign ioctl_dout     = dout_r;

`ifdef IOCTL_TX_CHECKSUM_EN
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    logic [7:0] checksum_r;

    // Session checksum: cleared entering SETUP, accumulates the byte of each WRITE.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            checksum_r <= 8'h00;
        end else if ((state_r == ST_IDLE) && (state_next_s == ST_SETUP)) begin
            checksum_r <= 8'h00;
        end else if (state_r == ST_WRITE) begin
            checksum_r <= sum8(checksum_r, dout_r);
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_ioctl_tx.sv
// Randomized bench for ioctl_tx: a source model feeds bytes, a monitor logs the session,
// and each session is judged against the transmitter's protocol rules.
module tb_ioctl_tx;
    localparam int ADDR_W = 25;
    localparam int WR_GAP = 3;
    localparam int TAIL   = 4;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        start_index;
    logic [ADDR_W-1:0] start_len;
    logic              abort;
    logic              busy, done, aborted;
    logic [7:0]        src_data;
    logic              src_valid;
    logic              src_ready;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        checksum;

    ioctl_tx #(.ADDR_W(ADDR_W), .WR_GAP(WR_GAP), .TAIL(TAIL)) dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .start_index(start_index),
        .start_len(start_len), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .checksum(checksum)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Session monitor: logs writes, download window, done pulse and protocol violations.
    logic              mon_en = 1'b0;
    logic [7:0]        exp_index = 8'h00;
    int                dl_cnt, dl_first, dl_last, done_cnt, done_cyc, rdy_cnt;
    int                idx_bad, busy_bad, wr_rdy_bad;
    logic              done_ab;
    logic [7:0]        done_ck;
    int                wr_cyc_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [7:0]        wr_data_q[$];

    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (ioctl_wr) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(ioctl_addr);
                wr_data_q.push_back(ioctl_dout);
                if (src_ready) wr_rdy_bad++;
            end
            if (ioctl_download) begin
                if (dl_cnt == 0) dl_first = cyc;
                dl_last = cyc;
                dl_cnt++;
                if (ioctl_index != exp_index) idx_bad++;
            end
            if (busy != ioctl_download) busy_bad++;
            if (src_ready) rdy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_ab  = aborted;
                done_ck  = checksum;
            end
        end else begin
            dl_cnt = 0; dl_first = 0; dl_last = 0; done_cnt = 0; done_cyc = 0; rdy_cnt = 0;
            idx_bad = 0; busy_bad = 0; wr_rdy_bad = 0; done_ab = 1'b0; done_ck = 8'h00;
            wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        end
    end

    logic [7:0] bytes_a [16];

    // mode: 0 plain, 1 abort collides with accept of byte abort_byte, 3 abort held during TAIL
    task automatic run_session(input string nm, input logic [7:0] idx, input int len,
                               input int stall, input bit rnd, input int mode,
                               input int abort_byte, input bit fixed, input bit busy_start);
        int nxt, wait_left, cur_w, sum_w, t0, abort_cyc, exp_n, last_wr;
        bit fin, tail_phase;
        logic [7:0] ck;
        nxt = 0; sum_w = 0; abort_cyc = 0; fin = 1'b0; tail_phase = 1'b0;
        for (int i = 0; i < 16; i++)
            bytes_a[i] = fixed ? 8'(8'h11 * 8'(i + 1)) : 8'($urandom);
        cur_w = rnd ? int'($urandom_range(stall, 0)) : stall;
        wait_left = cur_w;
        mon_en = 1'b0;
        @(negedge clk_sys);
        @(posedge clk_sys); #1;
        exp_index = idx;
        mon_en = 1'b1;
        start = 1'b1; start_index = idx; start_len = ADDR_W'(len); src_valid = 1'b0;
        @(negedge clk_sys);
        t0 = cyc;
        for (int k = 0; k < 2000 && !fin; k++) begin
            @(posedge clk_sys); #1;
            start = 1'b0; abort = 1'b0;
            src_valid = (nxt < len) && (wait_left == 0);
            src_data  = (nxt < 16) ? bytes_a[nxt] : 8'h00;
            if (busy_start && k == 4) begin
                start = 1'b1; start_index = ~idx; start_len = ADDR_W'(len + 5);
            end
            if (mode == 3 && tail_phase) abort = 1'b1;
            #1;
            if (mode == 1 && src_valid && src_ready && nxt == abort_byte) begin
                abort = 1'b1;
                abort_cyc = cyc;
            end
            @(negedge clk_sys);
            if (done) fin = 1'b1;
            if (src_valid && src_ready) begin
                nxt++;
                sum_w += cur_w;
                cur_w = rnd ? int'($urandom_range(stall, 0)) : stall;
                wait_left = cur_w;
            end else if (src_ready && wait_left > 0) begin
                wait_left--;
            end
            if (ioctl_wr && nxt == len) tail_phase = 1'b1;
        end
        chk({nm, "_finished"}, 64'(fin), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_sys); #1;
            start = 1'b0; abort = 1'b0; src_valid = 1'b0;
            @(negedge clk_sys);
        end
        exp_n = (mode == 1) ? abort_byte : len;
        ck = 8'h00;
        for (int i = 0; i < exp_n; i++) ck = ck + bytes_a[i];
`ifndef IOCTL_TX_CHECKSUM_EN
        ck = 8'h00;
`endif
        chk({nm, "_consumed"}, 64'(nxt), 64'(exp_n));
        chk({nm, "_nwr"}, 64'(wr_addr_q.size()), 64'(exp_n));
        for (int i = 0; i < wr_addr_q.size() && i < exp_n; i++) begin
            chk($sformatf("%s_addr%0d", nm, i), 64'(wr_addr_q[i]), 64'(i));
            chk($sformatf("%s_data%0d", nm, i), 64'(wr_data_q[i]), 64'(bytes_a[i]));
            if (i > 0 && stall == 0)
                chk($sformatf("%s_space%0d", nm, i), 64'(wr_cyc_q[i] - wr_cyc_q[i-1]), 64'(WR_GAP + 1));
        end
        chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({nm, "_aborted"}, 64'(done_ab), (mode == 1) ? 64'd1 : 64'd0);
        chk({nm, "_checksum"}, 64'(done_ck), 64'(ck));
        chk({nm, "_index"}, 64'(idx_bad), 64'd0);
        chk({nm, "_busy"}, 64'(busy_bad), 64'd0);
        chk({nm, "_wr_rdy"}, 64'(wr_rdy_bad), 64'd0);
        if (mode != 1)
            chk({nm, "_rdy_cycles"}, 64'(rdy_cnt), 64'(sum_w + len));
        if (len == 0) begin
            chk({nm, "_dl_none"}, 64'(dl_cnt), 64'd0);
            chk({nm, "_done_at"}, 64'(done_cyc), 64'(t0 + 1));
        end else begin
            last_wr = (wr_cyc_q.size() > 0) ? wr_cyc_q[$] : 0;
            chk({nm, "_dl_first"}, 64'(dl_first), 64'(t0 + 1));
            chk({nm, "_dl_contig"}, 64'(dl_cnt), 64'(dl_last - dl_first + 1));
            chk({nm, "_dl_last"}, 64'(dl_last), 64'(((mode == 1) ? abort_cyc : last_wr) + TAIL));
            chk({nm, "_done_at"}, 64'(done_cyc), 64'(dl_last + 1));
        end
        mon_en = 1'b0;
    endtask

    initial begin
        bit seen;
        reset = 1'b1; start = 1'b0; start_index = 8'h00; start_len = '0;
        abort = 1'b0; src_data = 8'h00; src_valid = 1'b0;
        #1;
        chk("reset_async", {busy, done, aborted, src_ready, ioctl_download, ioctl_wr,
                            ioctl_index, ioctl_addr, ioctl_dout, checksum}, 64'h0);
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_hold", {busy, done, aborted, src_ready, ioctl_download, ioctl_wr,
                           ioctl_index, ioctl_addr, ioctl_dout, checksum}, 64'h0);
        reset = 1'b0;

        run_session("basic",   8'd0, 3, 0,  1'b0, 0, 0, 1'b1, 1'b0);
        run_session("stall",   8'd0, 2, 10, 1'b0, 0, 0, 1'b0, 1'b0);
        run_session("zero",    8'd1, 0, 0,  1'b0, 0, 0, 1'b0, 1'b0);
        run_session("collide", 8'd0, 5, 0,  1'b0, 1, 2, 1'b0, 1'b0);
        run_session("tailabt", 8'd1, 3, 0,  1'b0, 3, 0, 1'b0, 1'b0);
        run_session("busystr", 8'd1, 4, 0,  1'b0, 0, 0, 1'b0, 1'b1);

        // Reset asserted in the GAP after the first write.
        @(posedge clk_sys); #1;
        start = 1'b1; start_index = 8'd5; start_len = ADDR_W'(4);
        src_valid = 1'b1; src_data = 8'hA5;
        @(posedge clk_sys); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_sys);
            if (ioctl_wr) seen = 1'b1;
        end
        chk("midrst_wr_seen", 64'(seen), 64'd1);
        @(posedge clk_sys); #3;
        reset = 1'b1;
        #1;
        chk("midrst_outs", {busy, done, aborted, src_ready, ioctl_download, ioctl_wr,
                            ioctl_index, ioctl_addr, ioctl_dout, checksum}, 64'h0);
        src_valid = 1'b0;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        run_session("after_rst", 8'd254, 8, 0, 1'b0, 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++)
            run_session($sformatf("rand%0d", r), 8'($urandom), int'($urandom_range(12, 1)),
                        3, 1'b1, 0, 0, 1'b0, 1'b0);
        run_session("rand_collide", 8'($urandom), 6, 2, 1'b1, 1,
                    int'($urandom_range(5, 1)), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
